register_dump_unit: RTL and testbench

REGISTER_DUMP_UNIT -- requirements
Module: register_dump_unit

---
 rtl/register_dump_unit.sv | 104 ++++++++++
 tb/tb_register_dump_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_dump_unit.sv
// rtl/register_dump_unit.sv - streams NUM_REGS register-file words to a byte transmitter, MSB first
module register_dump_unit #(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dump_start,
    output logic [4:0]  read_register,
    input  logic [31:0] read_data,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_done,
    output logic        busy,
    output logic        dump_done
);

    localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SEND,
        WAIT_TX,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] shift_reg;
    logic [1:0]  byte_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (dump_start) state_next = READ;
            READ:    state_next = SEND;
            SEND:    state_next = WAIT_TX;
            WAIT_TX: begin
                if (tx_done) begin
                    if (byte_idx != 2'd3) begin
                        state_next = SEND;
                    end else if (read_register == LAST_REG) begin
                        state_next = DONE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The word is latched once per register, so read_data may change freely afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_register <= 5'd0;
            shift_reg     <= 32'd0;
            byte_idx      <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    read_register <= 5'd0;
                end
                READ: begin
                    shift_reg <= read_data;
                    byte_idx  <= 2'd0;
                end
                WAIT_TX: begin
                    if (tx_done) begin
                        if (byte_idx != 2'd3) begin
                            shift_reg <= {shift_reg[23:0], 8'h00};
                            byte_idx  <= byte_idx + 2'd1;
                        end else if (read_register != LAST_REG) begin
                            read_register <= read_register + 5'd1;
                        end
                    end
                end
                DONE: begin
                    read_register <= 5'd0;
                    shift_reg     <= 32'd0;
                    byte_idx      <= 2'd0;
                end
                default: begin
                    read_register <= read_register;
                end
            endcase
        end
    end

    assign tx_data   = shift_reg[31:24];
    assign tx_start  = (state == SEND);
    assign busy      = (state == READ) || (state == SEND) || (state == WAIT_TX);
    assign dump_done = (state == DONE);

endmodule

// File: tb/tb_register_dump_unit.sv
// tb/tb_register_dump_unit.sv - self-checking bench for register_dump_unit
module tb_register_dump_unit;

    logic        clk;
    logic        reset;
    logic        dump_start;
    logic [4:0]  read_register;
    logic [31:0] read_data;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic        tx_done_m;
    logic        tx_done_x;
    logic        busy;
    logic        dump_done;
    logic [31:0] rf [32];

    logic        ds1;
    logic [4:0]  rr1;
    logic [31:0] rd1;
    logic [7:0]  txd1;
    logic        ts1;
    logic        td1;
    logic        busy1;
    logic        dd1;

    int n_checks;
    int n_err;
    int n_tx;
    int n_txd;
    int n_dd;
    bit auto_tx;

    typedef struct {
        logic [7:0] b;
        logic [4:0] r;
    } exp_t;
    exp_t q[$];
    logic [7:0] q1[$];

    typedef struct {
        logic [31:0] rd;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
    } vec_t;
    vec_t vecs[5];

    assign read_data = rf[read_register];
    assign tx_done   = tx_done_m | tx_done_x;

    register_dump_unit #(.NUM_REGS(32)) dut (
        .clk(clk), .reset(reset), .dump_start(dump_start),
        .read_register(read_register), .read_data(read_data),
        .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
        .busy(busy), .dump_done(dump_done)
    );

    register_dump_unit #(.NUM_REGS(1)) dut1 (
        .clk(clk), .reset(reset), .dump_start(ds1),
        .read_register(rr1), .read_data(rd1),
        .tx_data(txd1), .tx_start(ts1), .tx_done(td1),
        .busy(busy1), .dump_done(dd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dump();
        for (int r = 0; r < 32; r++) begin
            for (int k = 0; k < 4; k++) begin
                exp_t e;
                case (k)
                    0:       e.b = 8'h11;
                    1:       e.b = 8'h22;
                    2:       e.b = 8'h33;
                    default: e.b = 8'(r);
                endcase
                e.r = 5'(r);
                q.push_back(e);
            end
        end
    endtask

    task automatic pulse_start();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
    endtask

    // poke: stray dump_start pulses while busy and in the DONE cycle
    task automatic wait_done(input int budget, input bit poke);
        int start_dd;
        bit ok;
        start_dd = n_dd;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            dump_start = 1'b0;
            if (poke && busy && (i % 97 == 50)) dump_start = 1'b1;
            if (poke && dump_done) dump_start = 1'b1;
            if (n_dd != start_dd) ok = 1'b1;
        end
        dump_start = 1'b0;
        chk("dump_done_timeout", 32'(ok), 32'd1);
    endtask

    // Transmitter model plus output monitor for the 32-register instance
    initial begin
        int cnt;
        exp_t e;
        cnt = 0;
        tx_done_m = 1'b0;
        forever begin
            @(negedge clk);
            tx_done_m = 1'b0;
            if (reset) begin
                cnt = 0;
            end else if (tx_start) begin
                if (q.size() == 0) begin
                    chk("extra_tx_start", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("tx_byte", 32'(tx_data), 32'(e.b));
                    chk("tx_reg", 32'(read_register), 32'(e.r));
                end
                n_tx++;
                if (auto_tx) cnt = 10;
            end else if (cnt != 0) begin
                cnt--;
                if (cnt == 0) begin
                    tx_done_m = 1'b1;
                    n_txd++;
                end
            end
            if (dump_done) n_dd++;
        end
    end

    task automatic run_vec(input vec_t v);
        bit got;
        int dd_cnt;
        q1.delete();
        rd1 = v.rd;
        ds1 = 1'b1;
        tick();
        ds1 = 1'b0;
        q1.push_back(v.b0);
        q1.push_back(v.b1);
        q1.push_back(v.b2);
        q1.push_back(v.b3);
        dd_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                if (ts1) got = 1'b1;
                else tick();
            end
            chk("v_tx_start_seen", 32'(got), 32'd1);
            if (got && q1.size() != 0) begin
                chk("v_byte", 32'(txd1), 32'(q1.pop_front()));
                chk("v_reg", 32'(rr1), 32'd0);
            end
            if (k == 0) rd1 = ~v.rd;
            if (k == 1) td1 = 1'b1;
            tick();
            td1 = 1'b0;
            tick();
            td1 = 1'b1;
            tick();
            td1 = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            if (dd1) dd_cnt++;
            tick();
        end
        chk("v_dump_done_count", 32'(dd_cnt), 32'd1);
        chk("v_busy_after", 32'(busy1), 32'd0);
    endtask

    initial begin
        int base_tx;
        int base_dd;
        int base_txd;
        bit got;
        bit bad;

        n_checks = 0; n_err = 0; n_tx = 0; n_txd = 0; n_dd = 0;
        auto_tx = 1'b1;
        reset = 1'b1; dump_start = 1'b0; tx_done_x = 1'b0;
        ds1 = 1'b0; rd1 = 32'd0; td1 = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h11223300 + 32'(i);

        vecs[0] = '{rd: 32'hFFFFFFFF, b0: 8'hFF, b1: 8'hFF, b2: 8'hFF, b3: 8'hFF};
        vecs[1] = '{rd: 32'h00000000, b0: 8'h00, b1: 8'h00, b2: 8'h00, b3: 8'h00};
        vecs[2] = '{rd: 32'h12345678, b0: 8'h12, b1: 8'h34, b2: 8'h56, b3: 8'h78};
        vecs[3] = '{rd: 32'hA55A0FF0, b0: 8'hA5, b1: 8'h5A, b2: 8'h0F, b3: 8'hF0};
        vecs[4] = '{rd: 32'h80000001, b0: 8'h80, b1: 8'h00, b2: 8'h00, b3: 8'h01};

        // Reset held 3 cycles, then 10 idle cycles with all outputs at zero
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_outputs", 32'({read_register, tx_data, tx_start, busy, dump_done}), 32'd0);
        end
        chk("dut1_idle_outputs", 32'({rr1, txd1, ts1, busy1, dd1}), 32'd0);

        // Full dump of 32 registers
        base_tx = n_tx; base_dd = n_dd;
        push_dump();
        pulse_start();
        wait_done(3000, 1'b0);
        chk("full_tx_count", 32'(n_tx - base_tx), 32'd128);
        chk("full_dump_done_count", 32'(n_dd - base_dd), 32'd1);
        chk("full_queue_empty", 32'(q.size()), 32'd0);
        repeat (20) tick();
        chk("full_busy_after", 32'(busy), 32'd0);
        chk("full_no_extra_done", 32'(n_dd - base_dd), 32'd1);

        // Same dump with stray dump_start and idle tx_done pulses
        for (int i = 0; i < 3; i++) begin
            tx_done_x = 1'b1; tick(); tx_done_x = 1'b0; tick();
        end
        chk("idle_tx_done_ignored", 32'({busy, tx_start}), 32'd0);
        base_tx = n_tx; base_dd = n_dd;
        push_dump();
        pulse_start();
        wait_done(3000, 1'b1);
        for (int i = 0; i < 30; i++) begin
            tx_done_x = (i % 3 == 0);
            tick();
        end
        tx_done_x = 1'b0;
        chk("stray_tx_count", 32'(n_tx - base_tx), 32'd128);
        chk("stray_dump_done_count", 32'(n_dd - base_dd), 32'd1);
        chk("stray_no_second_dump", 32'(busy), 32'd0);
        chk("stray_queue_empty", 32'(q.size()), 32'd0);

        // Reset one cycle after the 5th tx_done aborts the dump
        base_txd = n_txd; base_dd = n_dd;
        push_dump();
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (n_txd - base_txd == 5) got = 1'b1;
            else tick();
        end
        chk("fifth_tx_done_seen", 32'(got), 32'd1);
        reset = 1'b1;
        tick();
        chk("abort_outputs", 32'({read_register, tx_data, tx_start, busy, dump_done}), 32'd0);
        reset = 1'b0;
        q.delete();
        base_tx = n_tx;
        repeat (50) tick();
        chk("abort_no_tx_start", 32'(n_tx - base_tx), 32'd0);
        chk("abort_no_dump_done", 32'(n_dd - base_dd), 32'd0);
        push_dump();
        pulse_start();
        wait_done(3000, 1'b0);
        chk("restart_tx_count", 32'(n_tx - base_tx), 32'd128);

        // Transmitter stalls for 100 cycles after the first byte
        auto_tx = 1'b0;
        base_tx = n_tx;
        push_dump();
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (n_tx - base_tx == 1) got = 1'b1;
        end
        chk("stall_first_tx", 32'(got), 32'd1);
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (busy !== 1'b1 || tx_start !== 1'b0 || tx_data !== 8'h11) bad = 1'b1;
        end
        chk("stall_hold", 32'(bad), 32'd0);
        tx_done_x = 1'b1;
        tick();
        tx_done_x = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (n_tx - base_tx == 2) got = 1'b1;
        end
        chk("stall_second_tx", 32'(got), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q.delete();
        auto_tx = 1'b1;

        // Single-register instance, table-driven
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
